regfile_arbiter: RTL and testbench

//  Shares the single-port 64x16 coefficient/sample register file between NUM_REQ requesters
//  (host loader = 0, FIR MAC engine = 1, ...) through a round-robin arbiter.

---
 rtl/regfile_arbiter_pkg.sv | 27 ++
 rtl/regfile_arbiter_rr_pick.sv | 59 +++++
 rtl/regfile_arbiter.sv | 150 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the regfile arbiter: default widths, FSM encodings, index helpers.
// Latency: none (package only).
// Backpressure: n/a.
package regfile_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    // Encodings are shared with the FIR sequencer, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DATA  = 2'd3
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester examined k steps after the pointer, wrapping at n.
    function automatic int rr_slot(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: picks one requester from req, search starting after ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports: req (request vector), ptr (last winner) -> onehot (winner), idx (winner index), any (a winner exists).
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, ptr ignored).
module regfile_arbiter_rr_pick
    import regfile_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan from the top down so the lowest set index is the last to overwrite.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
                idx       = IDX_W'(k);
                any       = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] cand;

    // Visit ptr+1, ptr+2, ... wrapping; ptr itself is visited last so the
    // previous winner only wins again when nobody else is asking.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'(rr_slot(int'(ptr), k, NUM_REQ));
            if (!any && req[cand]) begin
                onehot[cand] = 1'b1;
                idx          = cand;
                any          = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single-port registered-read regfile between NUM_REQ requesters via a round-robin arbiter.
// Latency: write = gnt 1 cycle after the req-sample edge, regfile written at the next edge; read = rvalid 2 edges after gnt.
// Backpressure: requests are only sampled in IDLE; requesters hold req until their one-cycle gnt pulse.
//
// Ports: clock/resetn; req/we/addr/wdata per requester (slice i = [i*W +: W]); gnt/rvalid pulses per requester;
//        rdata shared read return; rf_address/rf_en_write/rf_data drive the regfile (rf_data tristate).
// Build option: ARB_FIXED_PRIO_EN -> fixed priority (lowest index wins), pointer held at 0.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rf_address,
    output logic                      rf_en_write,
    inout  wire  [DATA_W-1:0]         rf_data
);

    localparam int IDX_W = idx_width(NUM_REQ);

`ifdef ARB_FIXED_PRIO_EN
    localparam logic [IDX_W-1:0] PTR_RST = '0;
`else
    // Pointer at the last index makes requester 0 the first winner after reset.
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);
`endif

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]  wdata_q, wdata_nxt;
    logic [DATA_W-1:0]  rdata_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, rvalid_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               en_nxt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Only drive the bus while the regfile is told to write; rf_en_write is a
    // register cleared on the edge WRITE exits, so the regfile never sees both drivers.
    assign rf_data = rf_en_write ? wdata_q : {DATA_W{1'bz}};

    regfile_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_addr  = addr[int'(pick_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[int'(pick_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= '0;
            ptr         <= PTR_RST;
            wdata_q     <= '0;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            rf_address  <= '0;
            rf_en_write <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            wdata_q     <= wdata_nxt;
            gnt         <= gnt_nxt;
            rvalid      <= rvalid_nxt;
            rdata       <= rdata_nxt;
            rf_address  <= addr_nxt;
            rf_en_write <= en_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        wdata_nxt  = wdata_q;
        gnt_nxt    = '0;
        rvalid_nxt = '0;
        rdata_nxt  = rdata;
        addr_nxt   = rf_address;
        en_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nxt = pick_idx;
                    gnt_nxt   = pick_onehot;
                    addr_nxt  = sel_addr;
`ifdef ARB_FIXED_PRIO_EN
                    ptr_nxt   = '0;
`else
                    ptr_nxt   = pick_idx;
`endif
                    if (we[pick_idx]) begin
                        wdata_nxt = sel_wdata;
                        en_nxt    = 1'b1;
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_RD_ISSUE;
                    end
                end
            end

            // Bus is driven this cycle; the regfile captures it at the closing edge.
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end

            // Regfile loads its output register at the closing edge.
            ST_RD_ISSUE: begin
                state_nxt = ST_RD_DATA;
            end

            // Regfile output register is on the bus now; capture it for the owner.
            ST_RD_DATA: begin
                rdata_nxt         = rf_data;
                rvalid_nxt[owner] = 1'b1;
                state_nxt         = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural single-port registered-read regfile.
// Directed table of single transactions, hand sequences (alternation, reset mid-read), then random traffic vs a model.
// Requesters hold req until gnt and drop it on the following edge.
module tb_regfile_arbiter;

    localparam int NR = 2;
    localparam int AW = 6;
    localparam int DW = 16;

    logic               clock  = 1'b0;
    logic               resetn = 1'b0;
    logic [NR-1:0]      req    = '0;
    logic [NR-1:0]      we     = '0;
    logic [NR*AW-1:0]   addr   = '0;
    logic [NR*DW-1:0]   wdata  = '0;
    logic [NR-1:0]      gnt;
    logic [NR-1:0]      rvalid;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      rf_address;
    logic               rf_en_write;
    wire  [DW-1:0]      rf_data;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rf_address  (rf_address),
        .rf_en_write (rf_en_write),
        .rf_data     (rf_data)
    );

    // Behavioural regfile: write on en_write, otherwise load the output register.
    logic [DW-1:0] rf_mem [64];
    logic [DW-1:0] rfm_q;
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat  = '0;

    always @(posedge clock) begin
        if (pl_en)            rf_mem[pl_addr]    <= pl_dat;
        else if (rf_en_write) rf_mem[rf_address] <= rf_data;
        else                  rfm_q              <= rf_mem[rf_address];
    end
    assign rf_data = rf_en_write ? {DW{1'bz}} : rfm_q;

    // Expected regfile contents.
    logic [DW-1:0] ref_mem [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic set_req(input int i, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = r;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        req    = '0;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    function automatic logic [DW-1:0] preload_val(input int a);
        logic [5:0] a6;
        a6 = 6'(a);
        if (a == 3) return 16'hAAAA;
        if (a == 4) return 16'h5555;
        return 16'h5A5A ^ {a6, a6[3:0], a6};
    endfunction

    task automatic preload_all();
        for (int a = 0; a < 64; a++) begin
            @(negedge clock);
            pl_en      = 1'b1;
            pl_addr    = 6'(a);
            pl_dat     = preload_val(a);
            ref_mem[a] = preload_val(a);
        end
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // One isolated transaction from a single requester, checked for timing and data.
    task automatic do_txn(input int who, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input string nm);
        int wait_n;
        bit seen;
        @(negedge clock);
        set_req(who, 1'b1, w, a, d);
        seen   = 1'b0;
        wait_n = 0;
        while (!seen && wait_n < 10) begin
            @(negedge clock);
            wait_n++;
            if (gnt[who]) seen = 1'b1;
        end
        if (!seen) begin
            timeout({nm, " gnt"});
            req[who] = 1'b0;
            return;
        end
        chk({nm, " gnt_lat"}, 32'(wait_n), 32'd1);
        chk({nm, " gnt"}, 32'(gnt), 32'(1) << who);
        chk({nm, " addr"}, 32'(rf_address), 32'(a));
        chk({nm, " en"}, 32'(rf_en_write), 32'(w));
        req[who] = 1'b0;
        if (w) begin
            chk({nm, " bus"}, 32'(rf_data), 32'(d));
            ref_mem[a] = d;
            @(negedge clock);
            chk({nm, " turnaround"}, 32'(rf_en_write), 32'd0);
        end else begin
            @(negedge clock);
            chk({nm, " early_rvalid"}, 32'(rvalid), 32'd0);
            @(negedge clock);
            chk({nm, " rvalid"}, 32'(rvalid), 32'(1) << who);
            chk({nm, " rdata"}, 32'(rdata), 32'(exp_rd));
        end
    endtask

    typedef struct {
        int            who;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [11];

    // Reference model: a transaction either owns the regfile for a number of
    // edges (write 1, read 2) or the arbiter is free and picks the next winner.
    int            m_busy;
    int            m_owner;
    int            m_ptr;
    bit            m_is_read;
    logic [DW-1:0] m_pend;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    logic [NR-1:0] m_gnt;
    logic [NR-1:0] m_rvalid;
    logic          m_en;

    task automatic model_reset();
        m_busy   = 0;
        m_owner  = 0;
        m_ptr    = NR - 1;
        m_rdata  = '0;
        m_addr   = '0;
        m_gnt    = '0;
        m_rvalid = '0;
        m_en     = 1'b0;
    endtask

    task automatic model_step();
        int w;
        logic [AW-1:0] a;
        m_gnt    = '0;
        m_rvalid = '0;
        m_en     = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_is_read) begin
                m_rvalid[m_owner] = 1'b1;
                m_rdata           = m_pend;
            end
        end else if (|req) begin
            w = -1;
`ifdef ARB_FIXED_PRIO_EN
            for (int i = NR - 1; i >= 0; i--) if (req[i]) w = i;
`else
            for (int k = 1; k <= NR; k++) begin
                if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
            m_ptr = w;
`endif
            a          = addr[w*AW +: AW];
            m_gnt[w]   = 1'b1;
            m_owner    = w;
            m_addr     = a;
            if (we[w]) begin
                ref_mem[a] = wdata[w*DW +: DW];
                m_en       = 1'b1;
                m_is_read  = 1'b0;
                m_busy     = 1;
            end else begin
                m_pend     = ref_mem[a];
                m_is_read  = 1'b1;
                m_busy     = 2;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [$];
        int nrv;
        int cyc;

        tbl[0]  = '{0, 1'b1, 6'd5,  16'h1234, 16'h0000};
        tbl[1]  = '{1, 1'b0, 6'd5,  16'h0000, 16'h1234};
        tbl[2]  = '{0, 1'b1, 6'd63, 16'hFFFF, 16'h0000};
        tbl[3]  = '{1, 1'b0, 6'd63, 16'h0000, 16'hFFFF};
        tbl[4]  = '{0, 1'b1, 6'd0,  16'h0000, 16'h0000};
        tbl[5]  = '{0, 1'b0, 6'd0,  16'h0000, 16'h0000};
        tbl[6]  = '{1, 1'b0, 6'd63, 16'h0000, 16'hFFFF};
        tbl[7]  = '{1, 1'b1, 6'h2A, 16'hBEEF, 16'h0000};
        tbl[8]  = '{0, 1'b0, 6'h2A, 16'h0000, 16'hBEEF};
        tbl[9]  = '{0, 1'b0, 6'd3,  16'h0000, 16'hAAAA};
        tbl[10] = '{1, 1'b0, 6'd4,  16'h0000, 16'h5555};

        // Reset values while resetn is low.
        #1;
        chk("rst gnt",    32'(gnt),         32'd0);
        chk("rst rvalid", 32'(rvalid),      32'd0);
        chk("rst rdata",  32'(rdata),       32'd0);
        chk("rst addr",   32'(rf_address),  32'd0);
        chk("rst en",     32'(rf_en_write), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Idle for 10 cycles: nothing happens, bus left to the regfile.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle outs", {gnt, rvalid, rf_en_write}, 32'd0);
        end

        preload_all();

        for (int i = 0; i < 11; i++) begin
            do_txn(tbl[i].who, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd,
                   $sformatf("vec%0d", i));
        end

        // Both requesters reading continuously: grants alternate.
        pulse_reset();
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 6'd3, '0);
        set_req(1, 1'b1, 1'b0, 6'd4, '0);
        nrv = 0;
        cyc = 0;
        while (order.size() < 6 && cyc < 80) begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (rvalid[i]) begin
                    nrv++;
                    chk($sformatf("alt rdata%0d", i), 32'(rdata), (i == 0) ? 32'hAAAA : 32'h5555);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (gnt[i]) begin
                    order.push_back(i);
                    req[i] = 1'b0;
                end else begin
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (4) begin
            @(negedge clock);
            for (int i = 0; i < NR; i++) begin
                if (rvalid[i]) begin
                    nrv++;
                    chk($sformatf("alt rdata%0d", i), 32'(rdata), (i == 0) ? 32'hAAAA : 32'h5555);
                end
            end
        end
        if (order.size() < 6) begin
            timeout("alt grants");
        end else begin
            for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                chk($sformatf("alt order%0d", k), 32'(order[k]), 32'd0);
`else
                chk($sformatf("alt order%0d", k), 32'(order[k]), 32'(k % 2));
`endif
            end
            chk("alt rvalid count", 32'(nrv), 32'd6);
        end

        // Reset asserted while the read sits in RD_ISSUE.
        @(negedge clock);
        set_req(1, 1'b1, 1'b0, 6'd4, '0);
        @(negedge clock);
        chk("rmid gnt", 32'(gnt), 32'd2);
        req    = '0;
        resetn = 1'b0;
        #1;
        chk("rmid outs", {gnt, rvalid, rf_en_write}, 32'd0);
        chk("rmid rdata", 32'(rdata), 32'd0);
        chk("rmid addr", 32'(rf_address), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rmid no rvalid", {gnt, rvalid}, 32'd0);
        end
        do_txn(1, 1'b0, 6'd4, '0, 16'h5555, "rmid after");

        // Random traffic against the model.
        pulse_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            chk("rnd gnt",    32'(gnt),         32'(m_gnt));
            chk("rnd rvalid", 32'(rvalid),      32'(m_rvalid));
            chk("rnd rdata",  32'(rdata),       32'(m_rdata));
            chk("rnd addr",   32'(rf_address),  32'(m_addr));
            chk("rnd en",     32'(rf_en_write), 32'(m_en));
            if (!rf_en_write) chk("rnd bus released", 32'(rf_data), 32'(rfm_q));
            for (int i = 0; i < NR; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom_range(0, 7)),
                            16'($urandom));
                end
            end
        end
        req = '0;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
